// File: rtl/move_link_receiver.sv
// Receive side of the inter-board Connect Four link: synchronizes the remote clock/data lines,
// shifts in a column code MSB first and emits a validated one-hot column strobe.
module move_link_receiver #(
  parameter int unsigned BITS           = 3,
  parameter int unsigned COLS           = 7,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_in,
  input  logic            bit_in,
  input  logic            enable,
  output logic [COLS-1:0] column_select,
  output logic [COLS-1:0] constant_col_sel,
  output logic            move_valid,
  output logic            frame_error,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(BITS + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BITS);
  localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  state_e            state_q, state_d;
  logic [BITS-1:0]   shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [COLS-1:0]   const_q, const_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic bit_s1_q, bit_s2_q;
  logic link_edge;

  logic [BITS:0]     shift_ext;
  logic [BITS-1:0]   shift_next;
  logic              code_legal;
  logic [COLS-1:0]   code_onehot;

  assign link_edge   = clk_s2_q & ~clk_prev_q;
  assign shift_ext   = {shift_q, bit_s2_q};
  assign shift_next  = shift_ext[BITS-1:0];
  assign code_legal  = 32'(shift_q) < COLS;
  assign code_onehot = COLS'(1) << shift_q;

  assign constant_col_sel = const_q;

  // Strobes decode the registered CHECK state so they land the cycle after the final edge.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    to_d          = to_q;
    const_d       = const_q;
    move_valid    = 1'b0;
    frame_error   = 1'b0;
    column_select = '0;
    busy          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (link_edge) begin
          shift_d = shift_next;
          cnt_d   = CntW'(1);
          to_d    = '0;
          state_d = (BITS == 1) ? StCheck : StShift;
        end
      end

      StShift: begin
        busy = 1'b1;
        if (link_edge) begin
          shift_d = shift_next;
          cnt_d   = cnt_q + CntW'(1);
          to_d    = '0;
          if (cnt_d == CntFull) state_d = StCheck;
        end else begin
          if (to_q != ToMax) to_d = to_q + ToW'(1);
          if (to_d == ToMax) begin
            frame_error = 1'b1;
            shift_d     = '0;
            cnt_d       = '0;
            to_d        = '0;
            state_d     = StIdle;
          end
        end
      end

      StCheck: begin
        busy = 1'b1;
        if (code_legal && enable) begin
          move_valid    = 1'b1;
          column_select = code_onehot;
          const_d       = code_onehot;
        end else begin
          frame_error = 1'b1;
        end
        shift_d = '0;
        cnt_d   = '0;
        to_d    = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      const_q    <= '0;
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      bit_s1_q   <= 1'b0;
      bit_s2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      const_q    <= const_d;
      clk_s1_q   <= clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      bit_s1_q   <= bit_in;
      bit_s2_q   <= bit_s1_q;
    end
  end

endmodule

// File: tb/tb_move_link_receiver.sv
// Self-checking bench for move_link_receiver: directed scenarios plus randomized frames
// checked against a frame-level outcome model.
module tb_move_link_receiver;

  localparam int Cols = 7;
  localparam int To   = 50;

  logic            clk = 1'b0;
  logic            reset;
  logic            clk_in;
  logic            bit_in;
  logic            enable;
  logic [Cols-1:0] column_select;
  logic [Cols-1:0] constant_col_sel;
  logic            move_valid;
  logic            frame_error;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_edge;
  logic [Cols-1:0] model_const;

  // Observed strobes: kind 0 = move_valid, 1 = frame_error.
  int              ev_kind[$];
  int              ev_cyc[$];
  logic [Cols-1:0] ev_col[$];

  move_link_receiver #(
    .BITS          (3),
    .COLS          (Cols),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_in          (clk_in),
    .bit_in          (bit_in),
    .enable          (enable),
    .column_select   (column_select),
    .constant_col_sel(constant_col_sel),
    .move_valid      (move_valid),
    .frame_error     (frame_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (move_valid === 1'b1) begin
      ev_kind.push_back(0); ev_cyc.push_back(cyc); ev_col.push_back(column_select);
    end
    if (frame_error === 1'b1) begin
      ev_kind.push_back(1); ev_cyc.push_back(cyc); ev_col.push_back(column_select);
    end
    if (reset === 1'b0) begin
      checks++;
      if ((move_valid !== 1'b1 && column_select !== '0) ||
          (move_valid === 1'b1 && (frame_error !== 1'b0 || !$onehot(column_select)))) begin
        failures++;
        $display("FAIL invariant cyc=%0d: move_valid=%b frame_error=%b column_select=%b",
                 cyc, move_valid, frame_error, column_select);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [Cols-1:0] onehot(input int code);
    logic [Cols-1:0] one;
    one = 1;
    return one << code;
  endfunction

  // Rising edge of clk_in is driven right after posedge n; the receiver should see it in cycle n+2.
  task automatic send_bit(input logic b);
    int lo, hi;
    lo = $urandom_range(2, 8);
    hi = $urandom_range(2, 8);
    @(posedge clk); #1;
    clk_in = 1'b0; bit_in = b;
    repeat (lo) @(posedge clk);
    #1; clk_in = 1'b1; last_edge = cyc + 2;
    repeat (hi) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] code);
    for (int i = 2; i >= 0; i--) send_bit(code[i]);
  endtask

  task automatic clear_events();
    ev_kind.delete(); ev_cyc.delete(); ev_col.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; bit_in = 1'b1; clk_in = 1'b0;
    model_const = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      clk_in = ~clk_in;
      checks++;
      if ({move_valid, frame_error, busy, column_select, constant_col_sel} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got mv=%b fe=%b busy=%b cs=%b ccs=%b want all 0",
                 i, move_valid, frame_error, busy, column_select, constant_col_sel);
      end
    end
    clk_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_events();
    repeat (5) @(posedge clk); #1;
    checks++;
    if (ev_kind.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got events=%0d busy=%b want 0 events busy=0",
               ev_kind.size(), busy);
    end
  endtask

  task automatic test_legal();
    int e;
    enable = 1'b1;
    clear_events();
    send_frame(3'd5);
    e = last_edge;
    repeat (6) @(posedge clk); #1;
    model_const = onehot(5);
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 0 || ev_cyc[0] != e + 1 ||
        ev_col[0] !== 7'b0100000) begin
      failures++;
      $display("FAIL legal_frame: got n=%0d kind=%0d cyc=%0d col=%b want n=1 kind=0 cyc=%0d col=%b",
               ev_kind.size(), ev_kind.size() ? ev_kind[0] : -1, ev_cyc.size() ? ev_cyc[0] : -1,
               ev_col.size() ? ev_col[0] : 7'bx, e + 1, 7'b0100000);
    end
    checks++;
    if (constant_col_sel !== 7'b0100000) begin
      failures++;
      $display("FAIL legal_held: got %b want %b", constant_col_sel, 7'b0100000);
    end
  endtask

  task automatic test_illegal();
    int e;
    clear_events();
    send_frame(3'd7);
    e = last_edge;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 1 || ev_cyc[0] != e + 1) begin
      failures++;
      $display("FAIL illegal_code: got n=%0d kind=%0d cyc=%0d want n=1 kind=1 cyc=%0d",
               ev_kind.size(), ev_kind.size() ? ev_kind[0] : -1,
               ev_cyc.size() ? ev_cyc[0] : -1, e + 1);
    end
    checks++;
    if (constant_col_sel !== model_const) begin
      failures++;
      $display("FAIL illegal_held: got %b want %b", constant_col_sel, model_const);
    end
  endtask

  task automatic test_timeout();
    int e;
    clear_events();
    send_bit(1'b0);
    send_bit(1'b1);
    e = last_edge;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_busy_mid: got %b want 1", busy);
    end
    repeat (60) @(posedge clk); #1;
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 1 || ev_cyc[0] != e + To) begin
      failures++;
      $display("FAIL timeout_error: got n=%0d kind=%0d cyc=%0d want n=1 kind=1 cyc=%0d",
               ev_kind.size(), ev_kind.size() ? ev_kind[0] : -1,
               ev_cyc.size() ? ev_cyc[0] : -1, e + To);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy_after: got %b want 0", busy);
    end
    clear_events();
    send_frame(3'd2);
    e = last_edge;
    repeat (6) @(posedge clk); #1;
    model_const = onehot(2);
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 0 || ev_cyc[0] != e + 1 ||
        ev_col[0] !== 7'b0000100) begin
      failures++;
      $display("FAIL timeout_recover: got n=%0d col=%b want n=1 valid col=%b",
               ev_kind.size(), ev_col.size() ? ev_col[0] : 7'bx, 7'b0000100);
    end
  endtask

  task automatic test_enable_low();
    clear_events();
    enable = 1'b0;
    send_frame(3'd2);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 1) begin
      failures++;
      $display("FAIL enable_low: got n=%0d kind=%0d want n=1 kind=1",
               ev_kind.size(), ev_kind.size() ? ev_kind[0] : -1);
    end
    clear_events();
    enable = 1'b1;
    send_frame(3'd2);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 0 || ev_col[0] !== 7'b0000100) begin
      failures++;
      $display("FAIL enable_high: got n=%0d col=%b want n=1 valid col=%b",
               ev_kind.size(), ev_col.size() ? ev_col[0] : 7'bx, 7'b0000100);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_events();
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy: got %b want 1", busy);
    end
    clk_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_const = '0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || constant_col_sel !== '0) begin
      failures++;
      $display("FAIL midreset_cleared: got busy=%b ccs=%b want 0/0", busy, constant_col_sel);
    end
    send_frame(3'd1);
    repeat (6) @(posedge clk); #1;
    model_const = onehot(1);
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] != 0 || ev_col[0] !== 7'b0000010) begin
      failures++;
      $display("FAIL midreset_frame: got n=%0d kind=%0d col=%b want n=1 valid col=%b",
               ev_kind.size(), ev_kind.size() ? ev_kind[0] : -1,
               ev_col.size() ? ev_col[0] : 7'bx, 7'b0000010);
    end
  endtask

  task automatic test_random_frames();
    int   code, e;
    logic en, legal;
    for (int n = 0; n < 24; n++) begin
      code = $urandom_range(0, 7);
      en   = 1'($urandom_range(0, 1));
      legal = (code < Cols) && en;
      enable = en;
      clear_events();
      send_frame(3'(code));
      e = last_edge;
      repeat (6) @(posedge clk); #1;
      if (legal) model_const = onehot(code);
      checks++;
      if (ev_kind.size() != 1 || ev_kind[0] != (legal ? 0 : 1) || ev_cyc[0] != e + 1 ||
          (legal && ev_col[0] !== onehot(code))) begin
        failures++;
        $display("FAIL random_frame %0d code=%0d en=%b: got n=%0d kind=%0d cyc=%0d col=%b want kind=%0d cyc=%0d",
                 n, code, en, ev_kind.size(), ev_kind.size() ? ev_kind[0] : -1,
                 ev_cyc.size() ? ev_cyc[0] : -1, ev_col.size() ? ev_col[0] : 7'bx,
                 legal ? 0 : 1, e + 1);
      end
      checks++;
      if (constant_col_sel !== model_const || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_held %0d: got ccs=%b busy=%b want ccs=%b busy=0",
                 n, constant_col_sel, busy, model_const);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_timeout();
    test_enable_low();
    test_reset_mid_frame();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
